// File: rtl/fetch_buffer.sv
// Circular instruction queue between fetch and dispatch: enqueues up to WAYS
// compacted instructions per cycle and presents the oldest WAYS entries as the dispatch window.
module fetch_buffer #(
    parameter int WAYS  = 3,
    parameter int DEPTH = 8,
    parameter int XLEN  = 32,
    localparam int PW   = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      branch_flush_en,
    input  logic [WAYS-1:0]           fetch_valid,
    input  logic [WAYS-1:0][31:0]     fetch_inst,
    input  logic [WAYS-1:0][XLEN-1:0] fetch_PC,
    input  logic [WAYS-1:0][XLEN-1:0] fetch_NPC,
    input  logic                      disp_stall_en,
    input  logic [PW-1:0]             disp_first_stall_idx,
    output logic [WAYS-1:0]           disp_valid,
    output logic [WAYS-1:0][31:0]     disp_inst,
    output logic [WAYS-1:0][XLEN-1:0] disp_PC,
    output logic [WAYS-1:0][XLEN-1:0] disp_NPC,
    output logic                      fetch_stall,
    output logic [CW-1:0]             count
);

    localparam int AW  = $clog2(DEPTH);
    localparam int EW  = $clog2(WAYS + 1);
    localparam logic [CW-1:0] WAYS_C   = CW'(WAYS);
    localparam logic [CW-1:0] STALL_TH = CW'(DEPTH - WAYS);
    localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(DEPTH);

    logic [31:0]     inst_mem [DEPTH];
    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [XLEN-1:0] npc_mem  [DEPTH];

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic                 enq_en;
    logic [EW-1:0]        enq_cnt;
    logic [WAYS-1:0][AW-1:0] lane_slot;
    logic [CW-1:0]        deq_cnt;
    logic [CW:0]          count_sum;

    assign fetch_stall = count_q > STALL_TH;
    assign count       = count_q;
    assign enq_en      = !fetch_stall && !branch_flush_en && !reset;

    // Compaction: each valid lane lands at tail plus the number of valid lanes below it.
    always_comb begin
        enq_cnt   = '0;
        lane_slot = '0;
        for (int i = 0; i < WAYS; i++) begin
            lane_slot[i] = tail_q + AW'(enq_cnt);
            enq_cnt      = enq_cnt + EW'(fetch_valid[i]);
        end
        if (!enq_en) begin
            enq_cnt = '0;
        end
    end

    always_comb begin
        deq_cnt = '0;
        if (disp_stall_en) begin
            deq_cnt = (CW'(disp_first_stall_idx) < count_q) ? CW'(disp_first_stall_idx) : count_q;
        end else begin
            deq_cnt = (WAYS_C < count_q) ? WAYS_C : count_q;
        end
    end

    always_comb begin
        count_sum = {1'b0, count_q} + (CW + 1)'(enq_cnt);
        head_d    = head_q + AW'(deq_cnt);
        tail_d    = tail_q + AW'(enq_cnt);
        count_d   = count_q + CW'(enq_cnt) - deq_cnt;
        if (branch_flush_en) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is never cleared; validity comes from count alone.
    always_ff @(posedge clock) begin
        for (int i = 0; i < WAYS; i++) begin
            if (enq_en && fetch_valid[i]) begin
                inst_mem[lane_slot[i]] <= fetch_inst[i];
                pc_mem[lane_slot[i]]   <= fetch_PC[i];
                npc_mem[lane_slot[i]]  <= fetch_NPC[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && !branch_flush_en) begin
            assert (count_sum <= DEPTH_C);
            assert (deq_cnt <= count_q);
        end
    end

    for (genvar gi = 0; gi < WAYS; gi++) begin : g_window
        logic [AW-1:0] rd_idx;
        assign rd_idx         = head_q + AW'(gi);
        assign disp_valid[gi] = CW'(gi) < count_q;
        assign disp_inst[gi]  = inst_mem[rd_idx];
        assign disp_PC[gi]    = pc_mem[rd_idx];
        assign disp_NPC[gi]   = npc_mem[rd_idx];
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer (WAYS=3, DEPTH=8): reset, stalls, compaction,
// backpressure, wrap-around and flush, with hand-computed expectations.
module tb_fetch_buffer;

    localparam int WAYS  = 3;
    localparam int DEPTH = 8;
    localparam int XLEN  = 32;

    logic                      clock = 1'b0;
    logic                      reset;
    logic                      branch_flush_en;
    logic [WAYS-1:0]           fetch_valid;
    logic [WAYS-1:0][31:0]     fetch_inst;
    logic [WAYS-1:0][XLEN-1:0] fetch_PC;
    logic [WAYS-1:0][XLEN-1:0] fetch_NPC;
    logic                      disp_stall_en;
    logic [1:0]                disp_first_stall_idx;
    logic [WAYS-1:0]           disp_valid;
    logic [WAYS-1:0][31:0]     disp_inst;
    logic [WAYS-1:0][XLEN-1:0] disp_PC;
    logic [WAYS-1:0][XLEN-1:0] disp_NPC;
    logic                      fetch_stall;
    logic [3:0]                count;

    int cmpd = 0;
    int mism = 0;

    fetch_buffer #(.WAYS(WAYS), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clock                (clock),
        .reset                (reset),
        .branch_flush_en      (branch_flush_en),
        .fetch_valid          (fetch_valid),
        .fetch_inst           (fetch_inst),
        .fetch_PC             (fetch_PC),
        .fetch_NPC            (fetch_NPC),
        .disp_stall_en        (disp_stall_en),
        .disp_first_stall_idx (disp_first_stall_idx),
        .disp_valid           (disp_valid),
        .disp_inst            (disp_inst),
        .disp_PC              (disp_PC),
        .disp_NPC             (disp_NPC),
        .fetch_stall          (fetch_stall),
        .count                (count)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle;
        fetch_valid          = '0;
        disp_stall_en        = 1'b0;
        disp_first_stall_idx = '0;
        branch_flush_en      = 1'b0;
    endtask

    task automatic set_group(input logic [2:0] v, input logic [31:0] pc0);
        fetch_valid = v;
        for (int i = 0; i < WAYS; i++) begin
            fetch_PC[i]   = pc0 + 32'(4 * i);
            fetch_NPC[i]  = pc0 + 32'(4 * i + 4);
            fetch_inst[i] = 32'hA500_0000 ^ (pc0 + 32'(4 * i));
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
        cmpd++; if (count !== 4'd0) begin mism++; $display("FAIL rst_count got %0d want 0", count); end
        cmpd++; if (disp_valid !== 3'b000) begin mism++; $display("FAIL rst_valid got %b want 000", disp_valid); end
        cmpd++; if (fetch_stall !== 1'b0) begin mism++; $display("FAIL rst_fstall got %b want 0", fetch_stall); end
        $display("reset: count=%0d valid=%b fetch_stall=%b", count, disp_valid, fetch_stall);
    endtask

    task automatic test_single_group;
        set_group(3'b111, 32'h0);
        tick();
        idle();
        cmpd++; if (disp_valid !== 3'b111) begin mism++; $display("FAIL sg_valid got %b want 111", disp_valid); end
        cmpd++; if (disp_PC[0] !== 32'h0) begin mism++; $display("FAIL sg_pc0 got %h want 0", disp_PC[0]); end
        cmpd++; if (disp_PC[1] !== 32'h4) begin mism++; $display("FAIL sg_pc1 got %h want 4", disp_PC[1]); end
        cmpd++; if (disp_PC[2] !== 32'h8) begin mism++; $display("FAIL sg_pc2 got %h want 8", disp_PC[2]); end
        cmpd++; if (disp_NPC[2] !== 32'hC) begin mism++; $display("FAIL sg_npc2 got %h want c", disp_NPC[2]); end
        cmpd++; if (disp_inst[1] !== 32'hA500_0004) begin mism++; $display("FAIL sg_inst1 got %h want a5000004", disp_inst[1]); end
        tick();
        cmpd++; if (count !== 4'd0) begin mism++; $display("FAIL sg_drain got %0d want 0", count); end
        $display("single_group: window pcs %h %h %h, count after dispatch=%0d", disp_PC[0], disp_PC[1], disp_PC[2], count);
    endtask

    task automatic test_partial_stall;
        disp_stall_en = 1'b1;
        disp_first_stall_idx = 2'd0;
        set_group(3'b111, 32'h0);
        tick();
        set_group(3'b111, 32'hC);
        tick();
        fetch_valid = '0;
        disp_first_stall_idx = 2'd1;
        cmpd++; if (count !== 4'd6) begin mism++; $display("FAIL ps_fill got %0d want 6", count); end
        cmpd++; if (fetch_stall !== 1'b1) begin mism++; $display("FAIL ps_fstall got %b want 1", fetch_stall); end
        tick();
        cmpd++; if (count !== 4'd5) begin mism++; $display("FAIL ps_idx1_count got %0d want 5", count); end
        cmpd++; if (disp_PC[0] !== 32'h4) begin mism++; $display("FAIL ps_idx1_pc0 got %h want 4", disp_PC[0]); end
        disp_first_stall_idx = 2'd0;
        tick();
        cmpd++; if (count !== 4'd5) begin mism++; $display("FAIL ps_idx0_count got %0d want 5", count); end
        cmpd++; if (disp_PC[2] !== 32'hC) begin mism++; $display("FAIL ps_idx0_pc2 got %h want c", disp_PC[2]); end
        idle();
        tick();
        cmpd++; if (count !== 4'd2) begin mism++; $display("FAIL ps_rel_count got %0d want 2", count); end
        cmpd++; if (disp_valid !== 3'b011) begin mism++; $display("FAIL ps_rel_valid got %b want 011", disp_valid); end
        cmpd++; if (disp_PC[0] !== 32'h10) begin mism++; $display("FAIL ps_rel_pc0 got %h want 10", disp_PC[0]); end
        tick();
        cmpd++; if (count !== 4'd0) begin mism++; $display("FAIL ps_drain got %0d want 0", count); end
        $display("partial_stall: stall idx1 then idx0, drained count=%0d", count);
    endtask

    task automatic test_sparse;
        set_group(3'b101, 32'h20);
        tick();
        idle();
        cmpd++; if (disp_valid !== 3'b011) begin mism++; $display("FAIL sp_valid got %b want 011", disp_valid); end
        cmpd++; if (disp_PC[0] !== 32'h20) begin mism++; $display("FAIL sp_pc0 got %h want 20", disp_PC[0]); end
        cmpd++; if (disp_PC[1] !== 32'h28) begin mism++; $display("FAIL sp_pc1 got %h want 28", disp_PC[1]); end
        cmpd++; if (count !== 4'd2) begin mism++; $display("FAIL sp_count got %0d want 2", count); end
        tick();
        cmpd++; if (count !== 4'd0) begin mism++; $display("FAIL sp_drain got %0d want 0", count); end
        $display("sparse: 101 compacted into lanes 0,1");
    endtask

    task automatic test_full_backpressure;
        disp_stall_en = 1'b1;
        disp_first_stall_idx = 2'd0;
        set_group(3'b111, 32'h40);
        tick();
        set_group(3'b111, 32'h4C);
        tick();
        cmpd++; if (count !== 4'd6) begin mism++; $display("FAIL fb_fill got %0d want 6", count); end
        cmpd++; if (fetch_stall !== 1'b1) begin mism++; $display("FAIL fb_fstall got %b want 1", fetch_stall); end
        set_group(3'b111, 32'h58);
        tick();
        idle();
        cmpd++; if (count !== 4'd6) begin mism++; $display("FAIL fb_drop_count got %0d want 6", count); end
        cmpd++; if (disp_PC[0] !== 32'h40) begin mism++; $display("FAIL fb_hold_pc0 got %h want 40", disp_PC[0]); end
        tick();
        cmpd++; if (count !== 4'd3) begin mism++; $display("FAIL fb_rel_count got %0d want 3", count); end
        cmpd++; if (fetch_stall !== 1'b0) begin mism++; $display("FAIL fb_rel_fstall got %b want 0", fetch_stall); end
        cmpd++; if (disp_PC[0] !== 32'h4C) begin mism++; $display("FAIL fb_rel_pc0 got %h want 4c", disp_PC[0]); end
        cmpd++; if (disp_PC[2] !== 32'h54) begin mism++; $display("FAIL fb_rel_pc2 got %h want 54", disp_PC[2]); end
        tick();
        cmpd++; if (count !== 4'd0) begin mism++; $display("FAIL fb_drain got %0d want 0", count); end
        $display("full_backpressure: group dropped at count 6, released to 3");
    endtask

    task automatic test_wrap;
        int       m_count = 0;
        int       groups  = 0;
        int       ndisp   = 0;
        int       deq;
        logic     m_stall;
        logic [31:0] exp_pc = 32'h100;
        for (int c = 0; c < 200 && ndisp < 30; c++) begin
            m_stall = (DEPTH - m_count) < WAYS;
            cmpd++; if (count !== 4'(m_count)) begin mism++; $display("FAIL wr_count cyc %0d got %0d want %0d", c, count, m_count); end
            cmpd++; if (fetch_stall !== m_stall) begin mism++; $display("FAIL wr_fstall cyc %0d got %b want %b", c, fetch_stall, m_stall); end
            disp_stall_en = (c % 3 == 2);
            disp_first_stall_idx = 2'd1;
            if (disp_stall_en) deq = (m_count < 1) ? m_count : 1;
            else               deq = (m_count < 3) ? m_count : 3;
            for (int l = 0; l < deq; l++) begin
                cmpd++;
                if (disp_valid[l] !== 1'b1 || disp_PC[l] !== exp_pc) begin
                    mism++;
                    $display("FAIL wr_pc cyc %0d lane %0d got v=%b pc=%h want v=1 pc=%h", c, l, disp_valid[l], disp_PC[l], exp_pc);
                end
                exp_pc = exp_pc + 32'd4;
                ndisp++;
            end
            if (groups < 10) set_group(3'b111, 32'h100 + 32'(12 * groups));
            else             fetch_valid = '0;
            if (groups < 10 && !m_stall) begin
                groups++;
                m_count = m_count + 3;
            end
            m_count = m_count - deq;
            tick();
        end
        idle();
        cmpd++; if (ndisp != 30) begin mism++; $display("FAIL wr_total got %0d want 30", ndisp); end
        cmpd++; if (count !== 4'd0) begin mism++; $display("FAIL wr_end_count got %0d want 0", count); end
        $display("wrap: %0d instructions dispatched in order, last pc %h", ndisp, exp_pc - 32'd4);
    endtask

    task automatic test_flush;
        disp_stall_en = 1'b1;
        disp_first_stall_idx = 2'd0;
        set_group(3'b111, 32'h200);
        tick();
        set_group(3'b011, 32'h20C);
        tick();
        cmpd++; if (count !== 4'd5) begin mism++; $display("FAIL fl_fill got %0d want 5", count); end
        branch_flush_en = 1'b1;
        set_group(3'b111, 32'h300);
        tick();
        idle();
        cmpd++; if (count !== 4'd0) begin mism++; $display("FAIL fl_count got %0d want 0", count); end
        cmpd++; if (disp_valid !== 3'b000) begin mism++; $display("FAIL fl_valid got %b want 000", disp_valid); end
        cmpd++; if (fetch_stall !== 1'b0) begin mism++; $display("FAIL fl_fstall got %b want 0", fetch_stall); end
        tick();
        cmpd++; if (count !== 4'd0) begin mism++; $display("FAIL fl_noenq got %0d want 0", count); end
        set_group(3'b001, 32'h400);
        tick();
        idle();
        cmpd++; if (disp_valid !== 3'b001) begin mism++; $display("FAIL fl_post_valid got %b want 001", disp_valid); end
        cmpd++; if (disp_PC[0] !== 32'h400) begin mism++; $display("FAIL fl_post_pc0 got %h want 400", disp_PC[0]); end
        tick();
        $display("flush: queue emptied, flushed group discarded, refill pc %h", 32'h400);
    endtask

    task automatic test_reset_mid;
        disp_stall_en = 1'b1;
        disp_first_stall_idx = 2'd0;
        set_group(3'b111, 32'h500);
        tick();
        cmpd++; if (count !== 4'd3) begin mism++; $display("FAIL rm_fill got %0d want 3", count); end
        reset = 1'b1;
        set_group(3'b111, 32'h50C);
        tick();
        reset = 1'b0;
        idle();
        cmpd++; if (count !== 4'd0) begin mism++; $display("FAIL rm_count got %0d want 0", count); end
        cmpd++; if (disp_valid !== 3'b000) begin mism++; $display("FAIL rm_valid got %b want 000", disp_valid); end
        tick();
        cmpd++; if (count !== 4'd0) begin mism++; $display("FAIL rm_noenq got %0d want 0", count); end
        $display("reset_mid: in-flight entries discarded, count=%0d", count);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        set_group(3'b000, 32'h0);
        repeat (2) tick();
        test_reset();
        test_single_group();
        test_partial_stall();
        test_sparse();
        test_full_backpressure();
        test_wrap();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpd, mism);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Circular instruction queue between the fetch stage and dispatch. Up to `WAYS` fetched instructions are enqueued per cycle, and the oldest `WAYS` entries are presented to dispatch as its input window. Entries leave the queue only as far as dispatch accepts them; a dispatch structural stall on lane k retires exactly lanes 0..k-1. A branch flush empties the queue in one cycle.

## Interface
Parameters:
- `WAYS`, default 3: superscalar width, matching `SUPERSCALAR_WAYS`.
- `DEPTH`, default 8: number of entries. Must be a power of two and ≥ 2·`WAYS`.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `branch_flush_en` in 1: mispredict flush.
- `fetch_valid` in `WAYS`: per-lane valid from fetch. May be sparse.
- `fetch_inst` in `WAYS`×32: instruction words.
- `fetch_PC` in `WAYS`×`XLEN`: instruction PCs.
- `fetch_NPC` in `WAYS`×`XLEN`: next PCs.
- `disp_stall_en` in 1: dispatch structural stall.
- `disp_first_stall_idx` in clog2(`WAYS`): lowest stalled lane.
- `disp_valid` out `WAYS`: window lane i holds an entry.
- `disp_inst`, `disp_PC`, `disp_NPC` out: window contents, oldest entry in lane 0.
- `fetch_stall` out 1: fetch must hold; the queue cannot accept a full group.
- `count` out clog2(`DEPTH`+1): current occupancy, for debug and perf.

## Operation
- **State:** entry array of {inst, PC, NPC}, `head`, `tail` (clog2(`DEPTH`) bits, wrap modulo `DEPTH`), and `count`.
- **Window:** lane i shows entry `head+i` mod `DEPTH`. `disp_valid[i] = (i < count)`. Window outputs are combinational from registered state only.
- **Dequeue amount `deq`:**
  - If `disp_stall_en`: `deq = min(disp_first_stall_idx, count)`.
  - Otherwise: `deq = min(WAYS, count)`.
  - `head += deq`.
- **Enqueue amount `enq`:**
  - If `fetch_stall`=0 and `branch_flush_en`=0: `enq` = popcount(`fetch_valid`). Valid lanes are compacted in ascending lane order into `tail`, `tail+1`, …, and `tail += enq`.
  - Otherwise: `enq = 0`, and fetch lanes are ignored.
- **Occupancy:** `count_next = count + enq - deq`. It must never exceed `DEPTH` or drop below 0; it is asserted in simulation.
- **`fetch_stall`:** `(DEPTH - count) < WAYS`. It is computed from registered count only, so it is conservative: same-cycle dequeues are not credited.
- **Flush:** `branch_flush_en`=1 forces `head`, `tail`, `count` to 0 next cycle. Enqueue and dequeue are suppressed that cycle. Entry storage is not cleared.
- **Priority:** `reset` > `branch_flush_en` > normal enqueue/dequeue.

## Timing
- **Reset:** `head`=`tail`=`count`=0 after the edge with `reset`=1. Then `disp_valid`=0, `fetch_stall`=0, `count`=0. `disp_inst`/`disp_PC`/`disp_NPC` are don't-care while their lane is invalid.
- **Latency:** an instruction enqueued at edge t appears in the window in cycle t+1. With no stall, it is removed at edge t+1.
- **Simultaneous enqueue and dequeue:** both apply in the same cycle. Dequeue reads pre-edge `head` entries; enqueue writes `tail` slots. There is no conflict because `fetch_stall` guarantees ≥ `WAYS` free slots.
- **Full/near-full:** with `count` > `DEPTH - WAYS`, `fetch_stall`=1 and fetch lanes are dropped. Fetch is required to hold its PC.
- **Empty:** `count`=0 gives an all-zero `disp_valid`; `deq`=0 regardless of the stall inputs.
- **Wrap-around:** `head`/`tail` increments wrap modulo `DEPTH`. Window lanes index modulo `DEPTH`.
- **Reset mid-operation:** identical to flush plus `fetch_stall`=0. All in-flight entries are discarded.
- **Flush with stall:** flush wins, and the queue is empty next cycle.

## Test plan
1. **Reset then single group.** Reset, then fetch_valid=3'b111 with PCs 0x0/0x4/0x8, no stall. Cycle+1: disp_valid=111 with PCs 0x0,0x4,0x8. Cycle+2: count=0.
2. **Partial dispatch stall.** Queue holds PCs 0x0..0x14 (count=6), fetch idle. Apply disp_stall_en=1, first_stall_idx=1. Next cycle: count=5, lane 0 PC=0x4. Apply first_stall_idx=0: count stays 5.
3. **Sparse compaction.** fetch_valid=3'b101 with PCs 0x20/–/0x28 into an empty queue. Next cycle: disp_valid=011, lane0 PC=0x20, lane1 PC=0x28, count=2.
4. **Full and backpressure.** Fill to count=6 with DEPTH=8, stall dispatch with first_stall_idx=0. fetch_stall=1; offered fetch group dropped; count stays 6. Release stall: count drops to 3 and fetch_stall falls.
5. **Wrap-around.** Run 10 groups of 3 with a 1-of-3 dispatch stall pattern. Dispatched PC sequence must be strictly +4 across the head wrap past entry 7→0, and nothing may be lost or duplicated.
6. **Flush.** With count=5, assert branch_flush_en together with a valid fetch group. Next cycle: count=0, disp_valid=000, and the flushed-cycle group is not enqueued.
